// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-side memory responder.
// Holds the FSM state encoding, default array geometry and the byte-lane merge helper.
package dm_responder_pkg;

    // Geometry shared with the instruction-side memory
    localparam int unsigned DM_DEPTH = 3072;
    localparam logic [31:0] DM_BASE  = 32'h0000_0000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_WAIT = S_WAIT,
        ST_RESP = S_RESP
    } state_t;

    // Replace each lane of old_w whose enable is set with the same lane of new_w
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] m;
        m = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/dm_array.sv
// DEPTH x 32 word store: async clear, sync byte-enabled write, registered read.
// Ports: idx_i word index; wr_en_i/be_i/wdata_i write; rd_en_i/rd_clr_i load rd_data_o; peek_o current word.
module dm_array
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH = DM_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] idx_i,
    input  logic          wr_en_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    input  logic          rd_en_i,
    input  logic          rd_clr_i,
    output logic [31:0]   rd_data_o,
    output logic [31:0]   peek_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // rd_clr_i forces a zero response for rejected accesses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q <= '0;
        end else if (rd_en_i) begin
            rd_q <= rd_clr_i ? '0 : mem_q[idx_i];
        end
    end

    assign rd_data_o = rd_q;
    assign peek_o    = mem_q[idx_i];

endmodule

// File: rtl/dm_responder.sv
// Data-side memory responder: req/ack bus target with WAIT_CYCLES wait states over dm_array.
// Ports: req/we/addr/byteen/wdata/pc request; ack/err/rdata/busy response; log_* write-log stream.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = DM_DEPTH,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = DM_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        busy,
    // One record per committed write, valid in the ack cycle: "@pc: *addr <= data"
    output logic        log_valid,
    output logic [31:0] log_pc,
    output logic [31:0] log_addr,
    output logic [31:0] log_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          ack_q, err_q, busy_q;
    logic          we_q;
    logic [31:0]   addr_q, wdata_q, pc_q;
    logic [3:0]    be_q;
    logic          log_vld_q;
    logic [31:0]   log_pc_q, log_addr_q, log_data_q;

    logic          in_idle, commit, bad, wr_go, rd_go;
    logic          f_we;
    logic [31:0]   f_addr, f_wdata, f_pc, f_idx, old_word;
    logic [3:0]    f_be;
    logic [AW-1:0] arr_idx;

    // With no wait states the commit happens on the capture edge, so the
    // live bus fields are used; otherwise the captured copies are.
    assign in_idle = (state_q == ST_IDLE);
    assign f_we    = in_idle ? we     : we_q;
    assign f_addr  = in_idle ? addr   : addr_q;
    assign f_be    = in_idle ? byteen : be_q;
    assign f_wdata = in_idle ? wdata  : wdata_q;
    assign f_pc    = in_idle ? pc     : pc_q;

    assign f_idx   = (f_addr - ADDR_BASE) >> 2;
    assign arr_idx = f_idx[AW-1:0];
    assign bad     = (f_addr[1:0] != 2'b00) || (f_idx >= 32'(DEPTH));

    assign commit = (in_idle && req && (WAIT_CYCLES == 0))
                 || ((state_q == ST_WAIT) && (cnt_q == CNT_LAST));
    assign wr_go  = commit && f_we && !bad && (f_be != 4'b0000);
    assign rd_go  = commit && (!f_we || bad);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            pc_q       <= '0;
            log_vld_q  <= 1'b0;
            log_pc_q   <= '0;
            log_addr_q <= '0;
            log_data_q <= '0;
        end else begin
            ack_q     <= commit;
            err_q     <= commit && bad;
            log_vld_q <= wr_go;
            if (wr_go) begin
                log_pc_q   <= f_pc;
                log_addr_q <= f_addr;
                log_data_q <= merge_lanes(old_word, f_wdata, f_be);
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        be_q    <= byteen;
                        wdata_q <= wdata;
                        pc_q    <= pc;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CW'(1);
                        end else begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_RESP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    dm_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .idx_i     (arr_idx),
        .wr_en_i   (wr_go),
        .be_i      (f_be),
        .wdata_i   (f_wdata),
        .rd_en_i   (rd_go),
        .rd_clr_i  (bad),
        .rd_data_o (rdata),
        .peek_o    (old_word)
    );

    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign log_valid = log_vld_q;
    assign log_pc    = log_pc_q;
    assign log_addr  = log_addr_q;
    assign log_data  = log_data_q;

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-side memory responder: the slave end of the CPU's load/store path, replacing the single-cycle data memory with a request/acknowledge bus target.
- Accepts one word-aligned access at a time, inserts a configurable number of wait states, then returns read data or commits byte-enabled write data.
- Sits between the M-stage bus master (the stall-capable pipeline) and the word-organised storage array.

Parameters:
- DEPTH, 3072, number of 32-bit words in the array.
- WAIT_CYCLES, 2, wait states between request capture and acknowledge (0 allowed).
- ADDR_BASE, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  access request; held with all fields stable until ack.
- we  input  1  1 = write, 0 = read.
- addr  input  32  byte address.
- byteen  input  4  write byte enables; bit i selects wdata[8i+7:8i].
- wdata  input  32  write data, already lane-aligned by the master.
- pc  input  32  PC of the issuing instruction, used for the write log only.
- ack  output  1  one-cycle completion pulse.
- err  output  1  valid with ack: access rejected.
- rdata  output  32  read word; valid with ack, held until next ack.
- busy  output  1  high from request capture through the ack cycle.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ack=0, err=0, busy=0, rdata=0, wait counter=0, all DEPTH words cleared to 0. Deassertion is sampled synchronously.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req=1 at an edge captures we/addr/byteen/wdata/pc into registers.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - busy rises at that same edge.
- WAIT: counter counts 1..WAIT_CYCLES. On reaching WAIT_CYCLES, next state is RESP.
- Commit edge (the edge entering RESP):
  - Read: rdata <= mem[idx].
  - Write: each lane with byteen[i]=1 is replaced. The merged word is written, and the log line "@%h: *%h <= %h" (pc, addr, merged word) is emitted.
  - ack<=1 and err set at the same edge.
- RESP: ack=1 for exactly one cycle. Next state is always IDLE, and ack/busy drop at that edge.
- Latency: ack is high in cycle N+WAIT_CYCLES+1, where N is the cycle in which req was first sampled high in IDLE.
- Throughput: the master must drop req in the cycle after ack. A req still high in IDLE is taken as a new access.
- Index: idx = (addr-ADDR_BASE)>>2. Use 32-bit subtraction; the result is unsigned.
- Error when addr[1:0]!=0 or idx>=DEPTH:
  - ack with err=1, rdata=0.
  - No array change, no log line.
- Write with byteen=4'b0000: ack with err=0, no array change, no log line.
- Read ignores byteen and wdata.
- req changes while busy: ignored. Captured fields are used.
- Reset asserted in WAIT or RESP: the pending write is dropped (never partially committed), ack is cleared immediately, and the array is cleared.
- err is meaningful only when ack=1 and is 0 otherwise.

Decomposition:
- Shared package:
  - State encoding constants S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2.
  - Byte-lane merge function (old word, new word, byteen -> merged word).
  - Default DEPTH/base constants, shared with the instruction-side memory.
- One natural sub-module, dm_array: a DEPTH x 32 storage array with asynchronous clear, synchronous byte-enabled write, and registered read. The FSM, counter, error check and log live in dm_responder.

Test Plan:
- WAIT_CYCLES=2: write addr=0x10, byteen=4'hF, wdata=0xDEADBEEF, pc=0x3008 -> ack in cycle N+3, err=0, log "@00003008: *00000010 <= deadbeef". Then read 0x10 -> rdata=0xDEADBEEF.
- Byte/half lanes: over word 0x11223344 at 0x20, write byteen=4'b0010 with wdata=0x0000AA00 -> read returns 0x1122AA44. Then write byteen=4'b1100 with wdata=0x55660000 -> read returns 0x5566AA44.
- Errors: read addr=0x22 -> ack, err=1, rdata=0. Write addr=DEPTH*4 -> ack, err=1, no log, word 0 unchanged.
- WAIT_CYCLES=0, back-to-back accesses with a one-cycle req gap -> ack in cycle N+1 for each, and busy toggles correctly.
- Reset mid-WAIT on a write of 0x12345678 to 0x40 -> ack never asserts, no log, and a later read of 0x40 returns 0.
- Field change while busy: switch addr from 0x44 to 0x48 in the cycle after capture -> the write lands at 0x44 and 0x48 stays unchanged.
